// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, default image
// base address, word width and instruction size in bytes.
package fetch_pkg;

   localparam logic [31:0] MEM_START_DEFAULT = 32'h8002_0000;
   localparam int          WORD_W            = 32;
   localparam logic [31:0] INSTR_BYTES       = 32'd4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_WR,
      LOAD_WAIT,
      READY,
      FETCH_RD,
      FETCH_WAIT,
      HOLD,
      DONE
   } state_t;

endpackage

// File: rtl/fetch_word_counter.sv
// Saturating count of loaded program words, plus the byte address one past
// the end of the image and a compare of a candidate pc against that address.
module fetch_word_counter
   import fetch_pkg::*;
#(
   parameter logic [31:0] MEM_START = MEM_START_DEFAULT,
   parameter int          CNT_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inc,
   input  logic [WORD_W-1:0] cmp_addr,
   output logic [CNT_W-1:0]  count,
   output logic              saturated,
   output logic [WORD_W-1:0] end_addr,
   output logic              at_end
);

   logic [CNT_W-1:0] count_q;

   // Word counter: advances once per completed load write, sticks at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or block order.
      if (reset) begin
         count_q <= '0;
      end else if (inc && !saturated) begin
         count_q <= count_q + 1'b1;
      end
   end

   // End-of-image address and compare against the candidate next pc.
   always_comb begin
      count     = count_q;
      saturated = &count_q;
      end_addr  = MEM_START + 32'(count_q) * INSTR_BYTES;
      at_end    = (cmp_addr == end_addr);
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program loader and sequential instruction fetcher sharing one memory port.
// Words streamed on load_* are written from MEM_START upward; start then
// reads them back one at a time and hands each to the decoder.
// Optional feature macro: FETCH_REDIRECT_EN adds redirect_valid/redirect_pc,
// letting the decoder replace pc+4 at handshake time.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] MEM_START = MEM_START_DEFAULT,
   parameter int          CNT_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [WORD_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              start,
   output logic [WORD_W-1:0] mem_address,
   output logic [WORD_W-1:0] mem_data_in,
   output logic              mem_read_write,
   output logic              mem_enable,
   input  logic [WORD_W-1:0] mem_data_out,
   input  logic              mem_busy,
`ifdef FETCH_REDIRECT_EN
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_pc,
`endif
   output logic [WORD_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [WORD_W-1:0] pc,
   output logic [CNT_W-1:0]  word_count,
   output logic              done
);

   state_t            state, state_nx;
   logic [WORD_W-1:0] pc_nx;
   logic [WORD_W-1:0] pc_inc;
   logic [WORD_W-1:0] load_addr_q;
   logic [WORD_W-1:0] load_data_q;
   logic              load_last_q;
   logic              capture_load;
   logic              capture_instr;
   logic              cnt_inc;
   logic              saturated;
   logic              at_end;
   logic [WORD_W-1:0] end_addr;
   logic [WORD_W-1:0] hold_pc;
   logic              hold_end;

   fetch_word_counter #(
      .MEM_START (MEM_START),
      .CNT_W     (CNT_W)
   ) u_counter (
      .clock     (clock),
      .reset     (reset),
      .inc       (cnt_inc),
      .cmp_addr  (pc_inc),
      .count     (word_count),
      .saturated (saturated),
      .end_addr  (end_addr),
      .at_end    (at_end)
   );

   assign pc_inc = pc + INSTR_BYTES;

`ifdef FETCH_REDIRECT_EN
   // Handshake target: a redirect overrides pc+4; leaving the image ends the pass.
   always_comb begin
      hold_pc  = redirect_valid ? redirect_pc : pc_inc;
      hold_end = redirect_valid ? !((redirect_pc >= MEM_START) && (redirect_pc < end_addr))
                                : at_end;
   end
`else
   // Handshake target: strictly sequential fetch.
   always_comb begin
      hold_pc  = pc_inc;
      hold_end = at_end;
   end
`endif

   // Next-state and register-enable decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave it unassigned and infer a latch.
      state_nx      = state;
      pc_nx         = pc;
      capture_load  = 1'b0;
      capture_instr = 1'b0;
      cnt_inc       = 1'b0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               if (saturated) begin
                  // Image full: accept and drop, but still honour the last flag.
                  if (load_last) state_nx = READY;
               end else begin
                  capture_load = 1'b1;
                  state_nx     = LOAD_WR;
               end
            end
         end
         LOAD_WR: begin
            if (!mem_busy) state_nx = LOAD_WAIT;
         end
         LOAD_WAIT: begin
            if (!mem_busy) begin
               cnt_inc  = 1'b1;
               state_nx = load_last_q ? READY : IDLE;
            end
         end
         READY, DONE: begin
            if (start) begin
               pc_nx    = MEM_START;
               state_nx = (word_count == '0) ? DONE : FETCH_RD;
            end
         end
         FETCH_RD: begin
            if (!mem_busy) state_nx = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (!mem_busy) begin
               capture_instr = 1'b1;
               state_nx      = HOLD;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               pc_nx    = hold_pc;
               state_nx = hold_end ? DONE : FETCH_RD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, pc, fetched instruction and latched load word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= MEM_START;
         instr       <= '0;
         load_addr_q <= MEM_START;
         load_data_q <= '0;
         load_last_q <= 1'b0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (capture_instr) instr <= mem_data_out;
         if (capture_load) begin
            load_addr_q <= end_addr;
            load_data_q <= load_data;
            load_last_q <= load_last;
         end
      end
   end

   // Outputs decoded from state; load_ready also drops while reset is held.
   always_comb begin
      load_ready     = (state == IDLE) && !reset;
      mem_enable     = (state == LOAD_WR) || (state == FETCH_RD);
      mem_read_write = (state != LOAD_WR);
      mem_address    = ((state == LOAD_WR) || (state == LOAD_WAIT)) ? load_addr_q : pc;
      mem_data_in    = load_data_q;
      instr_valid    = (state == HOLD);
      done           = (state == DONE);
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: load, zero-wait and stalled fetch,
// decoder backpressure, reset mid-fetch and counter saturation. A narrow
// counter (CNT_W=2) makes the saturation point reachable with a 3-word image.
// Redirect steps run only when FETCH_REDIRECT_EN is defined.
module tb_fetch_sequencer;

   localparam logic [31:0] MEM_START = 32'h8002_0000;
   localparam int          CNT_W     = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              load_valid;
   logic [31:0]       load_data;
   logic              load_last;
   logic              load_ready;
   logic              start;
   logic [31:0]       mem_address;
   logic [31:0]       mem_data_in;
   logic              mem_read_write;
   logic              mem_enable;
   logic [31:0]       mem_data_out = '0;
   logic              mem_busy;
   logic [31:0]       instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       pc;
   logic [CNT_W-1:0]  word_count;
   logic              done;
`ifdef FETCH_REDIRECT_EN
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] img [3] = '{32'h2402_0005, 32'h2403_0007, 32'h0043_2020};

   // Memory model: 16 words, busy for 4 cycles of each request when stalling.
   logic [31:0] mem_model [16];
   logic [31:0] wr_log [$];
   logic        stall = 1'b0;
   int          en_cnt = 0;

   always #5 clock = ~clock;

   assign mem_busy = stall && mem_enable && (en_cnt < 4);

   always @(posedge clock) begin
      if (mem_enable) en_cnt <= en_cnt + 1;
      else            en_cnt <= 0;
      if (mem_enable && !mem_busy) begin
         if (!mem_read_write) begin
            mem_model[mem_address[5:2]] <= mem_data_in;
            wr_log.push_back(mem_address);
         end else begin
            mem_data_out <= mem_model[mem_address[5:2]];
         end
      end
   end

   fetch_sequencer #(
      .MEM_START (MEM_START),
      .CNT_W     (CNT_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .load_valid     (load_valid),
      .load_data      (load_data),
      .load_last      (load_last),
      .load_ready     (load_ready),
      .start          (start),
      .mem_address    (mem_address),
      .mem_data_in    (mem_data_in),
      .mem_read_write (mem_read_write),
      .mem_enable     (mem_enable),
      .mem_data_out   (mem_data_out),
      .mem_busy       (mem_busy),
`ifdef FETCH_REDIRECT_EN
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`endif
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .pc             (pc),
      .word_count     (word_count),
      .done           (done)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!instr_valid && n < 40) begin
         tick();
         n++;
      end
      check("wait_instr_valid", instr_valid, 1);
   endtask

   task automatic load_word(input logic [31:0] data, input logic last, input int idx);
      int n = 0;
      while (!load_ready && n < 40) begin
         tick();
         n++;
      end
      check("load_ready_wait", load_ready, 1);
      load_valid = 1'b1;
      load_data  = data;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("load_wr_enable", mem_enable, 1);
      check("load_wr_rw", mem_read_write, 0);
      check("load_wr_addr", mem_address, MEM_START + 32'(4 * idx));
      check("load_wr_data", mem_data_in, data);
      n = 0;
      while (32'(word_count) != 32'(idx + 1) && n < 40) begin
         tick();
         n++;
      end
      check("load_word_count", 32'(word_count), 32'(idx + 1));
   endtask

   // One full pass over the 3-word image; exp_en = enable cycles per read.
   task automatic run_fetch(input int exp_en);
      int lat;
      int en;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lat = 0;
         en  = 0;
         while (!instr_valid && lat < 40) begin
            if (mem_enable) begin
               en++;
               check("fetch_addr_stable", mem_address, MEM_START + 32'(4 * i));
               check("fetch_rw", mem_read_write, 1);
            end
            tick();
            lat++;
         end
         check("fetch_latency", lat, exp_en + 1);
         check("fetch_enable_cycles", en, exp_en);
         check("fetch_instr", instr, img[i]);
         check("fetch_pc", pc, MEM_START + 32'(4 * i));
         check("done_before_end", done, 0);
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
      end
      check("done_after_pass", done, 1);
      check("done_mem_enable", mem_enable, 0);
      check("done_instr_valid", instr_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem_model[i] = '0;
      reset       = 1'b1;
      load_valid  = 1'b0;
      load_data   = '0;
      load_last   = 1'b0;
      start       = 1'b0;
      instr_ready = 1'b0;
`ifdef FETCH_REDIRECT_EN
      redirect_valid = 1'b0;
      redirect_pc    = '0;
`endif
      tick();
      tick();

      // Reset values while reset is held.
      check("rst_load_ready", load_ready, 0);
      check("rst_mem_enable", mem_enable, 0);
      check("rst_mem_rw", mem_read_write, 1);
      check("rst_mem_address", mem_address, MEM_START);
      check("rst_mem_data_in", mem_data_in, 0);
      check("rst_pc", pc, MEM_START);
      check("rst_instr", instr, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_done", done, 0);
      check("rst_word_count", 32'(word_count), 0);
      reset = 1'b0;
      tick();
      check("idle_load_ready", load_ready, 1);

      // start is ignored in IDLE.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("idle_start_mem_enable", mem_enable, 0);
      check("idle_start_load_ready", load_ready, 1);

      // Load the 3-word image with zero-wait memory.
      for (int i = 0; i < 3; i++) load_word(img[i], i == 2, i);
      check("load_write_count", wr_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check("load_write_addr", wr_log[i], MEM_START + 32'(4 * i));
         check("load_mem_contents", mem_model[i], img[i]);
      end
      check("ready_load_ready", load_ready, 0);
      check("ready_done", done, 0);
      check("ready_mem_enable", mem_enable, 0);

      // Zero-wait fetch pass, then a pass with 4 busy cycles per read.
      run_fetch(1);
      stall = 1'b1;
      run_fetch(5);
      stall = 1'b0;

      // Decoder holds off for 5 cycles: handoff must stay frozen.
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid();
      for (int k = 0; k < 5; k++) begin
         tick();
         check("hold_instr_valid", instr_valid, 1);
         check("hold_instr", instr, img[0]);
         check("hold_pc", pc, MEM_START);
         check("hold_mem_enable", mem_enable, 0);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("second_read_addr", mem_address, MEM_START + 32'd4);
      tick();
      check("fetch_wait_enable", mem_enable, 0);
      check("fetch_wait_valid", instr_valid, 0);

      // Reset mid-FETCH_WAIT: outputs return to reset values at once.
      #2;
      reset = 1'b1;
      #1;
      check("midrst_load_ready", load_ready, 0);
      check("midrst_mem_enable", mem_enable, 0);
      check("midrst_mem_rw", mem_read_write, 1);
      check("midrst_mem_address", mem_address, MEM_START);
      check("midrst_pc", pc, MEM_START);
      check("midrst_instr", instr, 0);
      check("midrst_instr_valid", instr_valid, 0);
      check("midrst_word_count", 32'(word_count), 0);
      tick();
      reset = 1'b0;
      tick();
      check("postrst_load_ready", load_ready, 1);
      check("postrst_word_count", 32'(word_count), 0);

      // Reload to saturation (3 words), then offer a 4th that must be dropped.
      for (int i = 0; i < 3; i++) load_word(img[i], 1'b0, i);
      check("sat_count", 32'(word_count), 3);
      check("sat_load_ready", load_ready, 1);
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      load_last  = 1'b1;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("sat_drop_mem_enable", mem_enable, 0);
      check("sat_drop_ready_state", load_ready, 0);
      check("sat_drop_count", 32'(word_count), 3);
      tick();
      check("sat_drop_write_count", wr_log.size(), 6);
      check("sat_drop_mem_word3", mem_model[3], 0);
      run_fetch(1);

`ifdef FETCH_REDIRECT_EN
      // Redirect back to the image base from the last word, then out of image.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wait_valid();
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
      end
      wait_valid();
      check("redir_from_pc", pc, MEM_START + 32'd8);
      redirect_valid = 1'b1;
      redirect_pc    = MEM_START;
      instr_ready    = 1'b1;
      tick();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      wait_valid();
      check("redir_pc", pc, MEM_START);
      check("redir_instr", instr, img[0]);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0000;
      instr_ready    = 1'b1;
      tick();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      check("redir_out_done", done, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
